// File: rtl/tx_arb_pkg.sv
// Shared types and sizing helpers for the tx_rr_arbiter slice.
// The default N/M/BURST constants are also used by the surrounding tx_rx subsystem.
package tx_arb_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_M     = 4;
  localparam int DEF_BURST = 2;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWN
  } arb_state_e;

  function automatic int idx_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int cnt_w(input int burst);
    return $clog2(burst + 1);
  endfunction

  localparam int DEF_IDX_W = idx_w(DEF_M);
  localparam int DEF_CNT_W = cnt_w(DEF_BURST);

endpackage

// File: rtl/tx_rr_arbiter_if.sv
// Producer/consumer bundle around the arbiter: M valid/ready producers in, one registered beat out.
interface tx_rr_arbiter_if
  import tx_arb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
);
  localparam int IW = idx_w(M);

  logic [M-1:0]   valid_i;
  logic [M*N-1:0] data_i;
  logic [M-1:0]   ready_o;
  logic           valid_o;
  logic [N-1:0]   data_o;
  logic [IW-1:0]  src_o;
  logic           ready_i;
  logic [M-1:0]   grant_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, src_o, grant_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, src_o, grant_o
  );

endinterface

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set bit of req searching ptr, ptr+1, ... wrapping at M.
// Purely combinational so any scheduler can reuse it.
module rr_pick
  import tx_arb_pkg::*;
#(
  parameter  int M  = DEF_M,
  localparam int IW = idx_w(M)
) (
  input  logic [M-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < M; k++) begin
      if (!found && req[(int'(ptr) + k) % M]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + k) % M);
      end
    end
  end

endmodule

// File: rtl/tx_rr_arbiter.sv
// Round-robin arbiter with bounded bursts feeding a single registered output slot.
// An owner keeps the grant for up to BURST beats, then the search restarts after it.
module tx_rr_arbiter
  import tx_arb_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int M     = DEF_M,
  parameter int BURST = DEF_BURST
) (
  input logic           clk,
  input logic           rst,
  tx_rr_arbiter_if.slave bus
);

  localparam int IW = idx_w(M);
  localparam int CW = cnt_w(BURST);
  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);
  localparam logic [CW-1:0] BURST_C  = CW'(BURST);

  arb_state_e    state, state_n;
  logic [IW-1:0] owner, owner_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [CW-1:0] beat_cnt, beat_cnt_n;
  logic [M-1:0]  grant_n;

  logic          load_en;
  logic          owner_keeps;
  logic [IW-1:0] pick_ptr;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          win_found;
  logic [IW-1:0] win;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  // Searching from owner+1 while owning lets a releasing owner's successor win in the same cycle.
  always_comb begin
    load_en     = !bus.valid_o || bus.ready_i;
    owner_keeps = (state == ARB_OWN) && bus.valid_i[owner] && (beat_cnt < BURST_C);
    pick_ptr    = (state == ARB_OWN) ? next_idx(owner) : ptr;
    win_found   = owner_keeps || pick_found;
    win         = owner_keeps ? owner : pick_idx;
  end

  rr_pick #(.M(M)) u_pick (
    .req   (bus.valid_i),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    bus.ready_o = '0;
    if (!rst && load_en && win_found) bus.ready_o[win] = 1'b1;
  end

  always_comb begin
    state_n    = state;
    owner_n    = owner;
    ptr_n      = ptr;
    beat_cnt_n = beat_cnt;
    if (load_en) begin
      unique case (state)
        ARB_IDLE: begin
          if (win_found) begin
            state_n    = ARB_OWN;
            owner_n    = win;
            beat_cnt_n = CW'(1);
          end
        end
        ARB_OWN: begin
          if (owner_keeps) begin
            beat_cnt_n = beat_cnt + 1'b1;
          end else begin
            ptr_n = next_idx(owner);
            if (win_found) begin
              owner_n    = win;
              beat_cnt_n = CW'(1);
            end else begin
              state_n    = ARB_IDLE;
              beat_cnt_n = '0;
            end
          end
        end
        default: state_n = ARB_IDLE;
      endcase
    end
    grant_n = '0;
    if (state_n == ARB_OWN) grant_n[owner_n] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      owner       <= '0;
      ptr         <= '0;
      beat_cnt    <= '0;
      bus.grant_o <= '0;
      bus.valid_o <= 1'b0;
      bus.data_o  <= '0;
      bus.src_o   <= '0;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      ptr         <= ptr_n;
      beat_cnt    <= beat_cnt_n;
      bus.grant_o <= grant_n;
      if (load_en) begin
        bus.valid_o <= win_found;
        if (win_found) begin
          bus.data_o <= bus.data_i[win*N +: N];
          bus.src_o  <= win;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_rr_arbiter.sv
// Directed bench for tx_rr_arbiter: a BURST=1 instance and a BURST=2 instance with hand-computed beats.
module tb_tx_rr_arbiter;
  import tx_arb_pkg::*;

  localparam int N = 4;
  localparam int M = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  tx_rr_arbiter_if #(.N(N), .M(M)) bus1 ();
  tx_rr_arbiter_if #(.N(N), .M(M)) bus2 ();

  tx_rr_arbiter #(.N(N), .M(M), .BURST(1)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  tx_rr_arbiter #(.N(N), .M(M), .BURST(2)) u_burst (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  logic       e_v;
  logic [1:0] e_s;
  logic [3:0] e_d;
  logic [3:0] e_g;

  task automatic idle_inputs();
    bus1.valid_i = '0; bus1.data_i = '0; bus1.ready_i = 1'b1;
    bus2.valid_i = '0; bus2.data_i = '0; bus2.ready_i = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus1.valid_o, bus1.src_o, bus1.data_o, bus1.grant_o, bus1.ready_o} !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_rr: got v=%0b src=%0d data=%h grant=%b ready=%b, expected all zero",
               bus1.valid_o, bus1.src_o, bus1.data_o, bus1.grant_o, bus1.ready_o);
    end
    vectors++;
    if ({bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o, bus2.ready_o} !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_burst: got v=%0b src=%0d data=%h grant=%b ready=%b, expected all zero",
               bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o, bus2.ready_o);
    end
    bus1.valid_i = '1;
    bus2.valid_i = '1;
    #1;
    vectors++;
    if ({bus1.ready_o, bus2.ready_o} !== 8'h00) begin
      miscompares++;
      $display("FAIL ready_in_reset: got %b/%b expected 0000/0000", bus1.ready_o, bus2.ready_o);
    end
    idle_inputs();
    rst = 1'b0;
    step();
    vectors++;
    if ({bus2.valid_o, bus2.grant_o, bus2.ready_o} !== 9'h0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got v=%0b grant=%b ready=%b expected 0/0000/0000",
               bus2.valid_o, bus2.grant_o, bus2.ready_o);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] e_r;
    do_reset();
    bus1.data_i  = 16'h4321;
    bus1.valid_i = 4'b1111;
    #1;
    vectors++;
    if (bus1.ready_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL rr_first_ready: got %b expected 0001", bus1.ready_o);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      e_s = 2'(k % 4);
      e_d = 4'(k % 4 + 1);
      e_g = 4'(1 << (k % 4));
      e_r = 4'(1 << ((k + 1) % 4));
      vectors++;
      if ({bus1.valid_o, bus1.src_o, bus1.data_o, bus1.grant_o} !== {1'b1, e_s, e_d, e_g}) begin
        miscompares++;
        $display("FAIL rr_beat[%0d]: got v=%0b src=%0d data=%h grant=%b, expected v=1 src=%0d data=%h grant=%b",
                 k, bus1.valid_o, bus1.src_o, bus1.data_o, bus1.grant_o, e_s, e_d, e_g);
      end
      vectors++;
      if (bus1.ready_o !== e_r) begin
        miscompares++;
        $display("FAIL rr_ready[%0d]: got %b expected %b", k, bus1.ready_o, e_r);
      end
    end
    bus1.valid_i = '0;
    step();
    vectors++;
    if ({bus1.valid_o, bus1.grant_o} !== 5'h0) begin
      miscompares++;
      $display("FAIL rr_drain: got v=%0b grant=%b expected 0/0000", bus1.valid_o, bus1.grant_o);
    end
  endtask

  task automatic test_burst_lock();
    do_reset();
    bus2.data_i  = 16'h4321;
    bus2.valid_i = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      e_s = 2'(k / 2);
      e_d = 4'(k / 2 + 1);
      e_g = 4'(1 << (k / 2));
      vectors++;
      if ({bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o} !== {1'b1, e_s, e_d, e_g}) begin
        miscompares++;
        $display("FAIL burst_beat[%0d]: got v=%0b src=%0d data=%h grant=%b, expected v=1 src=%0d data=%h grant=%b",
                 k, bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o, e_s, e_d, e_g);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus2.valid_i = 4'b0100;
    bus2.data_i  = 16'h0500;
    step();
    bus2.ready_i = 1'b0;
    bus2.data_i  = 16'h0600;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(); else #1;
      vectors++;
      if ({bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o, bus2.ready_o} !==
          {1'b1, 2'd2, 4'h5, 4'b0100, 4'b0000}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got v=%0b src=%0d data=%h grant=%b ready=%b, expected v=1 src=2 data=5 grant=0100 ready=0000",
                 k, bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o, bus2.ready_o);
      end
    end
    bus2.ready_i = 1'b1;
    #1;
    vectors++;
    if (bus2.ready_o !== 4'b0100) begin
      miscompares++;
      $display("FAIL stall_release_ready: got %b expected 0100", bus2.ready_o);
    end
    step();
    vectors++;
    if ({bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o} !== {1'b1, 2'd2, 4'h6, 4'b0100}) begin
      miscompares++;
      $display("FAIL stall_next_beat: got v=%0b src=%0d data=%h grant=%b, expected v=1 src=2 data=6 grant=0100",
               bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o);
    end
    bus2.valid_i = '0;
    step();
    vectors++;
    if ({bus2.valid_o, bus2.grant_o} !== 5'h0) begin
      miscompares++;
      $display("FAIL stall_drain: got v=%0b grant=%b expected 0/0000", bus2.valid_o, bus2.grant_o);
    end
  endtask

  task automatic test_early_release();
    do_reset();
    bus2.data_i  = 16'hC0A0;
    bus2.valid_i = 4'b0010;
    step();
    vectors++;
    if ({bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o} !== {1'b1, 2'd1, 4'hA, 4'b0010}) begin
      miscompares++;
      $display("FAIL early_first: got v=%0b src=%0d data=%h grant=%b, expected v=1 src=1 data=a grant=0010",
               bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o);
    end
    bus2.valid_i = 4'b1000;
    #1;
    vectors++;
    if (bus2.ready_o !== 4'b1000) begin
      miscompares++;
      $display("FAIL early_ready: got %b expected 1000", bus2.ready_o);
    end
    step();
    vectors++;
    if ({bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o} !== {1'b1, 2'd3, 4'hC, 4'b1000}) begin
      miscompares++;
      $display("FAIL early_switch: got v=%0b src=%0d data=%h grant=%b, expected v=1 src=3 data=c grant=1000",
               bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o);
    end
    // Owner 1 releasing with nobody else waiting leaves the pointer at 2.
    do_reset();
    bus2.data_i  = 16'hC0A0;
    bus2.valid_i = 4'b0010;
    step();
    bus2.valid_i = 4'b0000;
    step();
    vectors++;
    if ({bus2.valid_o, bus2.grant_o} !== 5'h0) begin
      miscompares++;
      $display("FAIL early_idle: got v=%0b grant=%b expected 0/0000", bus2.valid_o, bus2.grant_o);
    end
    bus2.data_i  = 16'h4321;
    bus2.valid_i = 4'b1111;
    #1;
    vectors++;
    if (bus2.ready_o !== 4'b0100) begin
      miscompares++;
      $display("FAIL early_ptr_ready: got %b expected 0100", bus2.ready_o);
    end
    step();
    vectors++;
    if ({bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o} !== {1'b1, 2'd2, 4'h3, 4'b0100}) begin
      miscompares++;
      $display("FAIL early_ptr_beat: got v=%0b src=%0d data=%h grant=%b, expected v=1 src=2 data=3 grant=0100",
               bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o);
    end
  endtask

  task automatic test_sole_requester();
    do_reset();
    bus2.data_i  = 16'h0007;
    bus2.valid_i = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++;
      if ({bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o, bus2.ready_o} !==
          {1'b1, 2'd0, 4'h7, 4'b0001, 4'b0001}) begin
        miscompares++;
        $display("FAIL sole_beat[%0d]: got v=%0b src=%0d data=%h grant=%b ready=%b, expected v=1 src=0 data=7 grant=0001 ready=0001",
                 k, bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o, bus2.ready_o);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus2.data_i  = 16'h4321;
    bus2.valid_i = 4'b1111;
    repeat (3) step();
    vectors++;
    if ({bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o} !== {1'b1, 2'd1, 4'h2, 4'b0010}) begin
      miscompares++;
      $display("FAIL areset_pre: got v=%0b src=%0d data=%h grant=%b, expected v=1 src=1 data=2 grant=0010",
               bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o, bus2.ready_o} !== 15'h0) begin
      miscompares++;
      $display("FAIL areset_immediate: got v=%0b src=%0d data=%h grant=%b ready=%b, expected all zero",
               bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o, bus2.ready_o);
    end
    step();
    #3 rst = 1'b0;
    #1;
    vectors++;
    if (bus2.ready_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL areset_ready: got %b expected 0001", bus2.ready_o);
    end
    step();
    vectors++;
    if ({bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o} !== {1'b1, 2'd0, 4'h1, 4'b0001}) begin
      miscompares++;
      $display("FAIL areset_first: got v=%0b src=%0d data=%h grant=%b, expected v=1 src=0 data=1 grant=0001",
               bus2.valid_o, bus2.src_o, bus2.data_o, bus2.grant_o);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_backpressure();
    test_early_release();
    test_sole_requester();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tx_rr_arbiter.md
Name: tx_rr_arbiter

Overview:
- Shares one rx-style consumer between M tx-style producers using valid/ready handshakes.
- Arbitration is round-robin with bounded bursts: a winning requester keeps the grant for up to BURST consecutive beats.
- The winning beat is captured in a single registered output stage that drives the consumer with valid_o/data_o plus a source index.
- Sits between the tx instances and the rx instance in the tx_rx subsystem.

Parameters:
N, 4, data width per beat
M, 4, number of requesters (>=2)
BURST, 2, max consecutive beats granted to one owner (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
valid_i  input  M  per-requester beat valid
data_i  input  M*N  flattened requester data, requester i at bits [i*N +: N]
ready_o  output  M  per-requester accept, combinational
valid_o  output  1  registered beat valid to consumer
data_o  output  N  registered beat data
src_o  output  $clog2(M)  index of requester that supplied the current beat
ready_i  input  1  consumer ready
grant_o  output  M  one-hot current owner, all-zero when no owner (registered)

Behaviour:
- Reset (async, rst=1): valid_o=0, data_o=0, src_o=0, grant_o=0, state=ARB_IDLE, ptr=0, beat_cnt=0. ready_o=0 while rst=1.
- Output slot:
  - load_en = !valid_o || ready_i.
  - Consumer-side transfer happens when valid_o && ready_i.
  - Beat is held stable while valid_o=1 and ready_i=0.
- Winner selection (combinational):
  - In ARB_OWN with valid_i[owner]=1 and beat_cnt<BURST: winner=owner.
  - Otherwise: first i with valid_i[i]=1, searching ptr, ptr+1, ... mod M.
  - No valid request: no winner.
- ready_o[i] = load_en && winner exists && winner==i. At most one bit set. Depends on valid_i, never on ready_o.
- Requester transfer when valid_i[w] && ready_o[w]:
  - Next cycle: data_o=data_i[w], src_o=w, valid_o=1. Latency 1 cycle.
  - Full throughput: 1 beat/cycle while ready_i=1.
- If load_en=1 and there is no winner: valid_o<=0 next cycle.
- FSM:
  - ARB_IDLE, on transfer from w: go ARB_OWN, owner=w, beat_cnt=1, grant_o=onehot(w).
  - ARB_OWN, transfer from owner: beat_cnt++.
  - ARB_OWN, release: when beat_cnt reaches BURST after a transfer, or the owner shows valid_i=0 while load_en=1.
  - On release: ptr<=owner+1 mod M, beat_cnt<=0.
  - If another winner transfers in the release cycle, it becomes the new owner directly with beat_cnt=1. Otherwise go ARB_IDLE, grant_o=0.
  - ARB_OWN with load_en=0 (stall): no change. The owner keeps the grant even if its valid drops during the stall.
- Boundaries:
  - BURST=1: pure round-robin, owner changes every beat when others are requesting.
  - Sole active requester after release: re-wins immediately (search wraps), so there is no bubble.
  - ptr wraps M-1 -> 0.
  - beat_cnt width is $clog2(BURST+1) and never exceeds BURST.
  - Reset mid-burst or with valid_o=1: the pending beat is discarded and all state returns to reset values.

Decomposition:
- Package tx_arb_pkg holds:
  - arb_state_e {ARB_IDLE, ARB_OWN}
  - localparam helpers for index width $clog2(M) and counter width $clog2(BURST+1)
  - default N/M/BURST constants shared with tx_rx
- One sub-module, rr_pick:
  - Purely combinational rotate-priority encoder.
  - Inputs: req[M], ptr.
  - Outputs: found, idx.
  - Reusable by other schedulers in the codebase.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all valid_i=0 -> valid_o=0, ready_o=0, grant_o=0, src_o=0.
- Round-robin fairness: M=4, BURST=1, ready_i=1, all valid_i=1, data_i[i]=i+1 -> src_o sequence 0,1,2,3,0 on consecutive cycles, data_o 1,2,3,4,1.
- Burst lock: BURST=2, all valid, ready_i=1 -> src_o 0,0,1,1,2,2,3,3; grant_o=0001,0001,0010,...
- Backpressure: hold ready_i=0 for 3 cycles after first beat (data 0x5 from req 2) -> valid_o=1, data_o=0x5, src_o=2 stable, ready_o=0; next cycle after ready_i=1, the next beat loads.
- Early release: owner 1 drops valid after 1 of 2 beats while req 3 valid -> next granted src_o=3, ptr advanced to 2.
- Async reset mid-burst: assert rst between clock edges with valid_o=1 -> valid_o, grant_o clear immediately; after release, first grant goes to req 0 when all are valid.
